axi_stream_strip: RTL and testbench

Strips a per-packet header of 0..DATA_BYTE_WD-1 bytes from the front of an AXI-Stream packet. The header goes out on a side channel; the remaining payload is re-aligned to full beats on the output stream. It is the receive-side counterpart of the header-insert block: it sits after the link/ingress stream and before payload consumers. Byte order is MSB-first: byte lane DATA_BYTE_WD-1 is the first byte on the wire.

---
 rtl/axi_stream_strip_if.sv | 16 +
 rtl/axi_stream_strip.sv | 133 +++++++++++++
 tb/tb_axi_stream_strip.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_stream_strip_if.sv
// Generic AXI-Stream beat bundle used for the input, payload and header
// channels of axi_stream_strip.
interface axi_stream_strip_if #(
  parameter int DATA_WD = 32
);
  localparam int DATA_BYTE_WD = DATA_WD >> 3;

  logic                    valid;
  logic                    ready;
  logic [DATA_WD-1:0]      data;
  logic [DATA_BYTE_WD-1:0] keep;
  logic                    last;

  modport master (output valid, data, keep, last, input ready);
  modport slave  (input valid, data, keep, last, output ready);
endinterface

// File: rtl/axi_stream_strip.sv
// Removes an N-byte header (0..W-1) from the front of each packet, sends the
// first beat out as the header and re-aligns the remaining payload to full beats.
module axi_stream_strip #(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD >> 3,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  axi_stream_strip_if.slave      s_in,
  axi_stream_strip_if.master     m_out,
  input  logic                   valid_strip,
  output logic                   ready_strip,
  input  logic [BYTE_CNT_WD-1:0] byte_strip_cnt,
  axi_stream_strip_if.master     m_hdr
);

  localparam int SB_WD     = BYTE_CNT_WD + 1;
  localparam int BIT_SH_WD = $clog2(DATA_WD) + 1;
  localparam logic [DATA_BYTE_WD-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH} state_t;

  state_t                  state_q, state_d;
  logic [DATA_WD-1:0]      hold_data_q, hold_data_d;
  logic [DATA_BYTE_WD-1:0] hold_keep_q, hold_keep_d;
  logic [BYTE_CNT_WD-1:0]  n_q, n_d;
  logic                    hdr_valid_q, hdr_valid_d;
  logic [DATA_WD-1:0]      data_hdr_q, data_hdr_d;
  logic [DATA_BYTE_WD-1:0] keep_hdr_q, keep_hdr_d;

  logic [BYTE_CNT_WD-1:0]  cur_n;
  logic [DATA_BYTE_WD-1:0] tail_mask;
  logic                    extra;
  logic [SB_WD-1:0]        shift_bytes, rsh_bytes;
  logic [BIT_SH_WD-1:0]    shift_bits, rsh_bits;
  logic [DATA_WD-1:0]      low_data;
  logic [DATA_BYTE_WD-1:0] low_keep;
  logic                    first_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_data_q <= '0;
      hold_keep_q <= '0;
      n_q         <= '0;
      hdr_valid_q <= 1'b0;
      data_hdr_q  <= '0;
      keep_hdr_q  <= '0;
    end else begin
      state_q     <= state_d;
      hold_data_q <= hold_data_d;
      hold_keep_q <= hold_keep_d;
      n_q         <= n_d;
      hdr_valid_q <= hdr_valid_d;
      data_hdr_q  <= data_hdr_d;
      keep_hdr_q  <= keep_hdr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_data_d = hold_data_q;
    hold_keep_d = hold_keep_q;
    n_d         = n_q;
    hdr_valid_d = hdr_valid_q;
    data_hdr_d  = data_hdr_q;
    keep_hdr_d  = keep_hdr_q;
    s_in.ready  = 1'b0;
    ready_strip = 1'b0;
    m_out.valid = 1'b0;
    m_out.last  = 1'b0;

    // On the first beat the live strip count applies; afterwards the latched one.
    cur_n     = (state_q == IDLE) ? byte_strip_cnt : n_q;
    tail_mask = ALL_ONES >> cur_n;
    extra     = |(s_in.keep & tail_mask);

    shift_bytes = {1'b0, n_q};
    rsh_bytes   = SB_WD'(DATA_BYTE_WD) - shift_bytes;
    shift_bits  = BIT_SH_WD'(shift_bytes) << 3;
    rsh_bits    = BIT_SH_WD'(DATA_WD) - shift_bits;
    low_data    = (state_q == FLUSH) ? '0 : s_in.data;
    low_keep    = (state_q == FLUSH) ? '0 : s_in.keep;
    m_out.data  = (hold_data_q << shift_bits) | (low_data >> rsh_bits);
    m_out.keep  = (hold_keep_q << shift_bytes) | (low_keep >> rsh_bytes);

    first_fire = 1'b0;
    if (hdr_valid_q && m_hdr.ready) hdr_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        s_in.ready  = valid_strip && !hdr_valid_q;
        ready_strip = s_in.valid && !hdr_valid_q;
        first_fire  = s_in.valid && valid_strip && !hdr_valid_q;
        if (first_fire) begin
          n_d         = byte_strip_cnt;
          hold_data_d = s_in.data;
          hold_keep_d = s_in.keep;
          if (byte_strip_cnt != '0) begin
            hdr_valid_d = 1'b1;
            data_hdr_d  = s_in.data;
            keep_hdr_d  = ~tail_mask;
          end
          if (s_in.last) state_d = extra ? FLUSH : IDLE;
          else           state_d = STREAM;
        end
      end
      STREAM: begin
        m_out.valid = s_in.valid;
        s_in.ready  = m_out.ready;
        m_out.last  = s_in.last && !extra;
        if (s_in.valid && m_out.ready) begin
          hold_data_d = s_in.data;
          hold_keep_d = s_in.keep;
          if (s_in.last) state_d = extra ? FLUSH : IDLE;
        end
      end
      FLUSH: begin
        m_out.valid = 1'b1;
        m_out.last  = 1'b1;
        if (m_out.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_hdr.valid = hdr_valid_q;
  assign m_hdr.data  = data_hdr_q;
  assign m_hdr.keep  = keep_hdr_q;
  assign m_hdr.last  = 1'b0;

endmodule

// File: tb/tb_axi_stream_strip.sv
// Directed bench for axi_stream_strip: a byte-queue packet model predicts header
// and payload beats, and a negedge monitor compares every handshake against it.
module tb_axi_stream_strip;

  localparam int DW = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       valid_strip;
  logic       ready_strip;
  logic [1:0] byte_strip_cnt;

  axi_stream_strip_if #(.DATA_WD(DW)) in_if ();
  axi_stream_strip_if #(.DATA_WD(DW)) out_if ();
  axi_stream_strip_if #(.DATA_WD(DW)) hdr_if ();

  axi_stream_strip #(.DATA_WD(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_in          (in_if),
    .m_out         (out_if),
    .valid_strip   (valid_strip),
    .ready_strip   (ready_strip),
    .byte_strip_cnt(byte_strip_cnt),
    .m_hdr         (hdr_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [31:0] pkt_data[$];
  logic [3:0]  pkt_keep[$];

  logic [31:0] exp_data[$];
  logic [3:0]  exp_keep[$];
  logic        exp_last[$];
  logic [31:0] exp_hdr_data[$];
  logic [3:0]  exp_hdr_keep[$];

  logic [31:0] obs_data[$];
  logic [3:0]  obs_keep[$];
  logic        obs_last[$];
  logic [31:0] obs_hdr_data[$];
  logic [3:0]  obs_hdr_keep[$];

  logic [31:0] ed;
  logic [3:0]  ek;
  logic        el;

  localparam logic [31:0] A = 32'hA0A1A2A3;
  localparam logic [31:0] B = 32'hB0B1B2B3;
  localparam logic [31:0] C = 32'hC0C1C2C3;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mask_data(input logic [31:0] d, input logic [3:0] k);
    logic [31:0] r;
    r = d;
    for (int l = 0; l < 4; l++) if (!k[l]) r[l*8 +: 8] = 8'h00;
    return r;
  endfunction

  // Monitor: every accepted payload or header beat must match the model queue.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_if.valid && out_if.ready) begin
        if (exp_data.size() == 0) begin
          check_output("unexpected_payload", 32'(out_if.valid), 32'd0);
        end else begin
          ed = exp_data.pop_front();
          ek = exp_keep.pop_front();
          el = exp_last.pop_front();
          check_output("payload_keep", 32'(out_if.keep), 32'(ek));
          check_output("payload_data", mask_data(out_if.data, out_if.keep), mask_data(ed, ek));
          check_output("payload_last", 32'(out_if.last), 32'(el));
        end
        obs_data.push_back(mask_data(out_if.data, out_if.keep));
        obs_keep.push_back(out_if.keep);
        obs_last.push_back(out_if.last);
      end
      if (hdr_if.valid && hdr_if.ready) begin
        if (exp_hdr_keep.size() == 0) begin
          check_output("unexpected_header", 32'(hdr_if.valid), 32'd0);
        end else begin
          ed = exp_hdr_data.pop_front();
          ek = exp_hdr_keep.pop_front();
          check_output("header_data", hdr_if.data, ed);
          check_output("header_keep", 32'(hdr_if.keep), 32'(ek));
        end
        obs_hdr_data.push_back(hdr_if.data);
        obs_hdr_keep.push_back(hdr_if.keep);
      end
    end
  end

  // Builds the expected header/payload from the packet's byte list, then drives it.
  task automatic apply_stimulus(input int n);
    logic [7:0]  byte_q[$];
    logic [31:0] d;
    logic [3:0]  k;
    logic [3:0]  hk;
    int          cyc;
    logic        go;

    byte_q.delete();
    for (int i = 0; i < pkt_data.size(); i++)
      for (int l = 3; l >= 0; l--)
        if (pkt_keep[i][l]) byte_q.push_back(pkt_data[i][l*8 +: 8]);
    if (n > 0) begin
      hk = 4'b0000;
      for (int j = 0; j < n; j++) hk[3-j] = 1'b1;
      exp_hdr_data.push_back(pkt_data[0]);
      exp_hdr_keep.push_back(hk);
    end
    repeat (n) if (byte_q.size() > 0) void'(byte_q.pop_front());
    while (byte_q.size() > 0) begin
      d = '0;
      k = '0;
      for (int l = 0; l < 4 && byte_q.size() > 0; l++) begin
        d[31-8*l -: 8] = byte_q.pop_front();
        k[3-l] = 1'b1;
      end
      exp_data.push_back(d);
      exp_keep.push_back(k);
      exp_last.push_back(byte_q.size() == 0);
    end

    for (int i = 0; i < pkt_data.size(); i++) begin
      in_if.valid = 1'b1;
      in_if.data  = pkt_data[i];
      in_if.keep  = pkt_keep[i];
      in_if.last  = (i == pkt_data.size() - 1);
      if (i == 0) begin
        valid_strip    = 1'b1;
        byte_strip_cnt = 2'(n);
      end
      go  = 1'b0;
      cyc = 0;
      while (!go) begin
        @(negedge clk);
        go = in_if.ready;
        @(posedge clk);
        #1;
        cyc++;
        if (!go && cyc > 200) begin
          check_output("drive_timeout", 32'(cyc), 32'd0);
          in_if.valid = 1'b0;
          valid_strip = 1'b0;
          return;
        end
      end
      if (i == 0) begin
        valid_strip    = 1'b0;
        byte_strip_cnt = ~2'(n);
      end
    end
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
    in_if.data  = 32'hDEADBEEF;
    in_if.keep  = 4'hF;
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while ((exp_data.size() != 0 || exp_hdr_keep.size() != 0) && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 100) check_output("drain_timeout", 32'(cyc), 32'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    obs_data.delete();
    obs_keep.delete();
    obs_last.delete();
    obs_hdr_data.delete();
    obs_hdr_keep.delete();
  endtask

  task automatic load_abc();
    pkt_data = '{A, B, C};
    pkt_keep = '{4'hF, 4'hF, 4'hC};
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] d,
                            input logic [3:0] k, input logic l);
    if (idx < obs_data.size()) begin
      check_output({name, "_data"}, obs_data[idx], d);
      check_output({name, "_keep"}, 32'(obs_keep[idx]), 32'(k));
      check_output({name, "_last"}, 32'(obs_last[idx]), 32'(l));
    end else begin
      check_output({name, "_missing"}, 32'(obs_data.size()), 32'(idx + 1));
    end
  endtask

  task automatic check_hdr(input string name, input logic [31:0] d, input logic [3:0] k);
    check_output({name, "_count"}, 32'(obs_hdr_keep.size()), 32'd1);
    if (obs_hdr_keep.size() > 0) begin
      check_output({name, "_data"}, obs_hdr_data[0], d);
      check_output({name, "_keep"}, 32'(obs_hdr_keep[0]), 32'(k));
    end
  endtask

  initial begin
    logic [31:0] sd;
    logic [3:0]  sk;
    logic        sl;
    int          cyc;

    in_if.valid    = 1'b0;
    in_if.data     = '0;
    in_if.keep     = '0;
    in_if.last     = 1'b0;
    out_if.ready   = 1'b1;
    hdr_if.ready   = 1'b1;
    valid_strip    = 1'b0;
    byte_strip_cnt = '0;

    #2 rst_n = 1'b0;
    #10;
    check_output("rst_valid_out", 32'(out_if.valid), 32'd0);
    check_output("rst_last_out", 32'(out_if.last), 32'd0);
    check_output("rst_valid_hdr", 32'(hdr_if.valid), 32'd0);
    check_output("rst_data_hdr", hdr_if.data, 32'd0);
    check_output("rst_keep_hdr", 32'(hdr_if.keep), 32'd0);
    check_output("rst_ready_strip", 32'(ready_strip), 32'd0);
    check_output("rst_ready_in_lo", 32'(in_if.ready), 32'd0);
    valid_strip = 1'b1;
    #1;
    check_output("rst_ready_in_hi", 32'(in_if.ready), 32'd1);
    valid_strip = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // N=1: header plus a trailing flush beat
    clear_logs();
    load_abc();
    apply_stimulus(1);
    wait_drain();
    check_hdr("n1_hdr", A, 4'b1000);
    check_output("n1_count", 32'(obs_data.size()), 32'd3);
    check_beat("n1_b0", 0, 32'hA1A2A3B0, 4'hF, 1'b0);
    check_beat("n1_b1", 1, 32'hB1B2B3C0, 4'hF, 1'b0);
    check_beat("n1_b2", 2, 32'hC1000000, 4'h8, 1'b1);

    // N=3: payload fits without flush
    clear_logs();
    load_abc();
    apply_stimulus(3);
    wait_drain();
    check_hdr("n3_hdr", A, 4'b1110);
    check_output("n3_count", 32'(obs_data.size()), 32'd2);
    check_beat("n3_b0", 0, 32'hA3B0B1B2, 4'hF, 1'b0);
    check_beat("n3_b1", 1, 32'hB3C0C100, 4'hE, 1'b1);

    // N=0: passthrough delayed by one beat, no header
    clear_logs();
    load_abc();
    apply_stimulus(0);
    wait_drain();
    check_output("n0_hdr_count", 32'(obs_hdr_keep.size()), 32'd0);
    check_output("n0_count", 32'(obs_data.size()), 32'd3);
    check_beat("n0_b0", 0, A, 4'hF, 1'b0);
    check_beat("n0_b1", 1, B, 4'hF, 1'b0);
    check_beat("n0_b2", 2, 32'hC0C10000, 4'hC, 1'b1);

    // Single-beat packets with N=2
    clear_logs();
    pkt_data = '{A};
    pkt_keep = '{4'hE};
    apply_stimulus(2);
    wait_drain();
    check_hdr("s1_hdr", A, 4'b1100);
    check_output("s1_count", 32'(obs_data.size()), 32'd1);
    check_beat("s1_b0", 0, 32'hA2000000, 4'h8, 1'b1);

    clear_logs();
    pkt_data = '{A};
    pkt_keep = '{4'hC};
    apply_stimulus(2);
    wait_drain();
    check_hdr("s2_hdr", A, 4'b1100);
    check_output("s2_count", 32'(obs_data.size()), 32'd0);

    // Payload backpressure for three cycles mid-packet
    clear_logs();
    load_abc();
    fork
      apply_stimulus(1);
      begin
        cyc = 0;
        do begin
          @(posedge clk);
          #2;
          cyc++;
        end while (!out_if.valid && cyc < 50);
        if (cyc >= 50) check_output("stall_wait_timeout", 32'(cyc), 32'd0);
        out_if.ready = 1'b0;
        @(negedge clk);
        sd = out_if.data;
        sk = out_if.keep;
        sl = out_if.last;
        check_output("stall_ready_in0", 32'(in_if.ready), 32'd0);
        check_output("stall_valid_out", 32'(out_if.valid), 32'd1);
        repeat (2) begin
          @(negedge clk);
          check_output("stall_data", out_if.data, sd);
          check_output("stall_keep", 32'(out_if.keep), 32'(sk));
          check_output("stall_last", 32'(out_if.last), 32'(sl));
          check_output("stall_ready_in", 32'(in_if.ready), 32'd0);
        end
        @(posedge clk);
        #2 out_if.ready = 1'b1;
      end
    join
    wait_drain();
    check_output("bp_count", 32'(obs_data.size()), 32'd3);
    check_beat("bp_b0", 0, 32'hA1A2A3B0, 4'hF, 1'b0);
    check_beat("bp_b1", 1, 32'hB1B2B3C0, 4'hF, 1'b0);
    check_beat("bp_b2", 2, 32'hC1000000, 4'h8, 1'b1);

    // Pending header blocks the next packet's first beat
    clear_logs();
    hdr_if.ready = 1'b0;
    load_abc();
    apply_stimulus(2);
    in_if.valid    = 1'b1;
    in_if.data     = A;
    in_if.keep     = 4'hF;
    in_if.last     = 1'b0;
    valid_strip    = 1'b1;
    byte_strip_cnt = 2'd1;
    repeat (3) begin
      @(negedge clk);
      check_output("hdr_block_ready_in", 32'(in_if.ready), 32'd0);
      check_output("hdr_block_ready_strip", 32'(ready_strip), 32'd0);
    end
    @(posedge clk);
    #1 hdr_if.ready = 1'b1;
    load_abc();
    apply_stimulus(1);
    wait_drain();
    check_output("hb_hdr_count", 32'(obs_hdr_keep.size()), 32'd2);
    check_output("hb_count", 32'(obs_data.size()), 32'd5);
    check_beat("hb_b1", 1, 32'hB2B3C0C1, 4'hF, 1'b1);
    check_beat("hb_b4", 4, 32'hC1000000, 4'h8, 1'b1);

    // Reset in the middle of a packet, then a clean packet
    clear_logs();
    out_if.ready   = 1'b0;
    hdr_if.ready   = 1'b0;
    in_if.valid    = 1'b1;
    in_if.data     = A;
    in_if.keep     = 4'hF;
    in_if.last     = 1'b0;
    valid_strip    = 1'b1;
    byte_strip_cnt = 2'd1;
    @(posedge clk);
    #1;
    valid_strip = 1'b0;
    in_if.data  = B;
    @(negedge clk);
    check_output("pre_rst_valid_out", 32'(out_if.valid), 32'd1);
    check_output("pre_rst_valid_hdr", 32'(hdr_if.valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_output("mid_rst_valid_out", 32'(out_if.valid), 32'd0);
    check_output("mid_rst_valid_hdr", 32'(hdr_if.valid), 32'd0);
    in_if.valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n        = 1'b1;
    out_if.ready = 1'b1;
    hdr_if.ready = 1'b1;
    @(posedge clk);
    #1;
    load_abc();
    apply_stimulus(3);
    wait_drain();
    check_hdr("post_rst_hdr", A, 4'b1110);
    check_beat("post_rst_b0", 0, 32'hA3B0B1B2, 4'hF, 1'b0);
    check_beat("post_rst_b1", 1, 32'hB3C0C100, 4'hE, 1'b1);

    check_output("final_payload_left", 32'(exp_data.size()), 32'd0);
    check_output("final_header_left", 32'(exp_hdr_keep.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
